// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: accepts one EXU request at a time, checks
// alignment, issues a single aligned 8-byte bus transaction, waits for the
// response with a timeout, and presents the right-aligned result downstream.
module lsu_mem_ctrl #(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_wdt_op,
    input  logic        req_is_unsigned,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic [3:0]  out_wdt_op,
    output logic        out_is_unsigned,
    output logic        out_is_store,
    output logic [1:0]  out_err
);

    localparam int CNT_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wen_q, wen_d;
    logic [63:0]        addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [3:0]         wdt_q, wdt_d;
    logic               uns_q, uns_d;
    logic [63:0]        rdata_q, rdata_d;
    logic [1:0]         err_q, err_d;
    logic               live_q, live_d;

    logic               req_misaligned;
    logic [5:0]         shamt;
    logic [63:0]        width_mask;
    logic [7:0]         lane_mask;

    // Incoming request alignment check; a width code that is not one-hot counts as misaligned
    always_comb begin
        req_misaligned = 1'b1;
        case (req_wdt_op)
            4'b0001: req_misaligned = 1'b0;
            4'b0010: req_misaligned = req_addr[0];
            4'b0100: req_misaligned = |req_addr[1:0];
            4'b1000: req_misaligned = |req_addr[2:0];
            default: req_misaligned = 1'b1;
        endcase
    end

    // Byte-lane and data masks for the captured width, before shifting by the byte offset
    always_comb begin
        width_mask = '0;
        lane_mask  = '0;
        case (wdt_q)
            4'b0001: begin width_mask = 64'h0000_0000_0000_00FF; lane_mask = 8'h01; end
            4'b0010: begin width_mask = 64'h0000_0000_0000_FFFF; lane_mask = 8'h03; end
            4'b0100: begin width_mask = 64'h0000_0000_FFFF_FFFF; lane_mask = 8'h0F; end
            4'b1000: begin width_mask = 64'hFFFF_FFFF_FFFF_FFFF; lane_mask = 8'hFF; end
            default: begin width_mask = '0; lane_mask = '0; end
        endcase
    end

    assign shamt  = {addr_q[2:0], 3'b000};
    assign live_d = 1'b1;

    // Next-state and capture logic for the IDLE/REQ/WAIT/DONE sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wdt_d   = wdt_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wdt_d   = req_wdt_op;
                    uns_d   = req_is_unsigned;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (req_misaligned) begin
                        err_d   = 2'd1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 2'd0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = wen_q ? 64'd0 : ((mem_rsp_rdata >> shamt) & width_mask);
                    err_d   = 2'd0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(RSP_TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 2'd2;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and captured operands; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wdt_q   <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 2'd0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wdt_q   <= wdt_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

    assign req_ready       = (state_q == S_IDLE) && live_q;
    assign mem_req_valid   = (state_q == S_REQ);
    assign mem_req_wen     = wen_q;
    assign mem_req_addr    = {addr_q[63:3], 3'b000};
    assign mem_req_wdata   = wdata_q << shamt;
    assign mem_req_wmask   = wen_q ? (lane_mask << addr_q[2:0]) : 8'h00;
    assign out_valid       = (state_q == S_DONE);
    assign out_rdata       = rdata_q;
    assign out_wdt_op      = wdt_q;
    assign out_is_unsigned = uns_q;
    assign out_is_store    = wen_q;
    assign out_err         = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus random
// operations, each compared against a byte-level behavioural model.
module tb_lsu_mem_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_wdt_op;
    logic        req_is_unsigned;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic [3:0]  out_wdt_op;
    logic        out_is_unsigned;
    logic        out_is_store;
    logic [1:0]  out_err;

    int errors = 0;
    int checks = 0;

    lsu_mem_ctrl #(.RSP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wdt_op(req_wdt_op),
        .req_is_unsigned(req_is_unsigned),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_wdt_op(out_wdt_op), .out_is_unsigned(out_is_unsigned),
        .out_is_store(out_is_store), .out_err(out_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sizeOf(input logic [3:0] w);
        case (w)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return 8;
            default: return 0;
        endcase
    endfunction

    // One complete operation: rspDelay<0 means the bus never answers
    task automatic applyStimulus(input string tag, input logic wen, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [3:0] wdt, input logic uns,
                                 input int reqStall, input int rspDelay, input logic [63:0] rdata,
                                 input int outStall, input logic staleRsp);
        int          sz;
        int          off;
        logic        mis;
        logic        answered;
        logic [63:0] expAddr;
        logic [63:0] expWdata;
        logic [63:0] expRdata;
        logic [7:0]  expMask;
        logic [1:0]  expErr;

        sz       = sizeOf(wdt);
        off      = int'(addr[2:0]);
        mis      = (sz == 0) || ((off % sz) != 0);
        answered = (rspDelay >= 0) && (rspDelay < TMO);
        expAddr  = addr - 64'(off);
        expWdata = '0;
        expMask  = '0;
        expRdata = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= off) expWdata[8*i +: 8] = wdata[8*(i-off) +: 8];
        end
        if (wen) begin
            for (int i = 0; i < sz; i++) begin
                if (off + i < 8) expMask[off+i] = 1'b1;
            end
        end
        if (!wen && !mis && answered) begin
            for (int i = 0; i < sz; i++) expRdata[8*i +: 8] = rdata[8*(off+i) +: 8];
        end
        expErr = mis ? 2'd1 : (answered ? 2'd0 : 2'd2);

        req_valid       = 1'b1;
        req_wen         = wen;
        req_addr        = addr;
        req_wdata       = wdata;
        req_wdt_op      = wdt;
        req_is_unsigned = uns;
        checkOutput({tag, ".idle_ready"}, 64'(req_ready), 64'(1));
        step();
        req_valid       = 1'b0;
        req_wen         = 1'($urandom);
        req_addr        = {$urandom, $urandom};
        req_wdata       = {$urandom, $urandom};
        req_wdt_op      = 4'($urandom);
        req_is_unsigned = 1'($urandom);

        if (mis) begin
            checkOutput({tag, ".no_bus"}, 64'(mem_req_valid), 64'(0));
        end else begin
            for (int s = 0; s <= reqStall; s++) begin
                checkOutput({tag, ".mreq_valid"}, 64'(mem_req_valid), 64'(1));
                checkOutput({tag, ".mreq_addr"}, mem_req_addr, expAddr);
                checkOutput({tag, ".mreq_wmask"}, 64'(mem_req_wmask), 64'(expMask));
                checkOutput({tag, ".mreq_wen"}, 64'(mem_req_wen), 64'(wen));
                if (wen) checkOutput({tag, ".mreq_wdata"}, mem_req_wdata, expWdata);
                checkOutput({tag, ".busy_ready"}, 64'(req_ready), 64'(0));
                if (s == reqStall) begin
                    mem_req_ready = 1'b1;
                    mem_rsp_valid = staleRsp;
                    mem_rsp_rdata = {$urandom, $urandom};
                end
                step();
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (answered) begin
                for (int c = 0; c < rspDelay; c++) begin
                    checkOutput({tag, ".wait_nodone"}, 64'(out_valid), 64'(0));
                    step();
                end
                checkOutput({tag, ".wait_nodone"}, 64'(out_valid), 64'(0));
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = rdata;
                step();
                mem_rsp_valid = 1'b0;
                mem_rsp_rdata = {$urandom, $urandom};
            end else begin
                for (int c = 0; c < TMO; c++) begin
                    checkOutput({tag, ".wait_nodone"}, 64'(out_valid), 64'(0));
                    step();
                end
            end
        end

        for (int s = 0; s <= outStall; s++) begin
            checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(1));
            checkOutput({tag, ".out_err"}, 64'(out_err), 64'(expErr));
            checkOutput({tag, ".out_rdata"}, out_rdata, expRdata);
            checkOutput({tag, ".out_wdt_op"}, 64'(out_wdt_op), 64'(wdt));
            checkOutput({tag, ".out_unsigned"}, 64'(out_is_unsigned), 64'(uns));
            checkOutput({tag, ".out_store"}, 64'(out_is_store), 64'(wen));
            checkOutput({tag, ".done_ready"}, 64'(req_ready), 64'(0));
            checkOutput({tag, ".done_nobus"}, 64'(mem_req_valid), 64'(0));
            if (s == outStall) out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        checkOutput({tag, ".back_idle"}, 64'(out_valid), 64'(0));
        checkOutput({tag, ".back_ready"}, 64'(req_ready), 64'(1));
    endtask

    // Directed scenarios followed by randomized operations
    initial begin
        logic [3:0]  w;
        logic [63:0] a;
        int          sz;
        int          pick;
        int          dly;

        rst             = 1'b1;
        req_valid       = 1'b0;
        req_wen         = 1'b0;
        req_addr        = '0;
        req_wdata       = '0;
        req_wdt_op      = '0;
        req_is_unsigned = 1'b0;
        mem_req_ready   = 1'b0;
        mem_rsp_valid   = 1'b0;
        mem_rsp_rdata   = '0;
        out_ready       = 1'b0;

        #1;
        checkOutput("rst.req_ready", 64'(req_ready), 64'(0));
        checkOutput("rst.mreq_valid", 64'(mem_req_valid), 64'(0));
        checkOutput("rst.out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst.out_err", 64'(out_err), 64'(0));
        checkOutput("rst.out_rdata", out_rdata, 64'(0));
        step();
        step();
        checkOutput("rst.held_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        step();
        checkOutput("rst.ready_after", 64'(req_ready), 64'(1));

        applyStimulus("lb", 1'b0, 64'h0000_0000_8000_0003, 64'h0, 4'b0001, 1'b0,
                      0, 0, 64'h1122_3344_5566_7788, 0, 1'b1);
        applyStimulus("sh", 1'b1, 64'h0000_0000_8000_0006, 64'hABCD, 4'b0010, 1'b0,
                      0, 1, 64'h0, 0, 1'b0);
        applyStimulus("lw_mis", 1'b0, 64'h0000_0000_8000_0002, 64'h0, 4'b0100, 1'b0,
                      0, 0, 64'h0, 0, 1'b0);
        applyStimulus("bad_wdt", 1'b0, 64'h0000_0000_8000_0000, 64'h0, 4'b0011, 1'b1,
                      0, 0, 64'h0, 0, 1'b0);
        applyStimulus("ld_tmo", 1'b0, 64'h0000_0000_0000_1000, 64'h0, 4'b1000, 1'b0,
                      0, -1, 64'h0, 0, 1'b0);
        applyStimulus("ld_last", 1'b0, 64'h0000_0000_0000_1000, 64'h0, 4'b1000, 1'b0,
                      0, TMO - 1, 64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0);
        applyStimulus("stall", 1'b0, 64'h0000_0000_0000_2004, 64'h0, 4'b0100, 1'b1,
                      3, 2, 64'h0123_4567_89AB_CDEF, 2, 1'b0);

        // Reset during WAIT, then a stale response while idle
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_addr   = 64'h0000_0000_0000_3000;
        req_wdt_op = 4'b1000;
        step();
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst.out_valid", 64'(out_valid), 64'(0));
        checkOutput("mid_rst.mreq_valid", 64'(mem_req_valid), 64'(0));
        checkOutput("mid_rst.req_ready", 64'(req_ready), 64'(0));
        checkOutput("mid_rst.out_rdata", out_rdata, 64'(0));
        step();
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        checkOutput("stale.ready", 64'(req_ready), 64'(1));
        checkOutput("stale.out_valid", 64'(out_valid), 64'(0));
        step();
        checkOutput("stale.out_valid2", 64'(out_valid), 64'(0));
        mem_rsp_valid = 1'b0;
        applyStimulus("after_rst", 1'b0, 64'h0000_0000_0000_3005, 64'h0, 4'b0001, 1'b1,
                      1, 0, 64'hA5A5_5A5A_1234_5678, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 8) w = 4'b0001 << (pick % 4);
            else          w = 4'($urandom_range(0, 15));
            sz = sizeOf(w);
            a  = {$urandom, $urandom};
            if (sz > 0 && $urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'(sz - 1);
            dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
            applyStimulus("rnd", 1'($urandom), a, {$urandom, $urandom}, w, 1'($urandom),
                          int'($urandom_range(0, 3)), dly, {$urandom, $urandom},
                          int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter RSP_TIMEOUT, default 255, meaning max cycles waited in WAIT for mem_rsp_valid before a bus error is reported.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  EXU load/store request valid
- req_ready  out  1  block can accept request
- req_wen  in  1  1=store, 0=load
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- req_wdt_op  in  4  one-hot width: bit0=8, bit1=16, bit2=32, bit3=64
- req_is_unsigned  in  1  load zero-extend flag, carried through
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_wen  out  1  bus write enable
- mem_req_addr  out  64  req_addr with bits[2:0] forced to 0
- mem_req_wdata  out  64  store data shifted left by 8*addr[2:0]
- mem_req_wmask  out  8  byte-lane strobe
- mem_rsp_valid  in  1  bus response valid (read data or write ack)
- mem_rsp_rdata  in  64  aligned 8-byte word
- out_valid  out  1  result valid toward the load-extension stage / WBU
- out_ready  in  1  consumer accepts result
- out_rdata  out  64  load bytes shifted right by 8*addr[2:0], upper bits zero (unextended)
- out_wdt_op  out  4  captured width, for the extension stage
- out_is_unsigned  out  1  captured flag
- out_is_store  out  1  completed op was a store
- out_err  out  2  0=ok, 1=misaligned, 2=bus timeout

Function
REQ-003 SHALL implement FSM IDLE, REQ, WAIT, DONE; req_ready=1 only in IDLE.
REQ-004 IDLE: on req_valid&req_ready, SHALL capture wen, addr, wdata, wdt_op, is_unsigned; next state REQ if aligned, else DONE with out_err=1 and no bus activity.
REQ-005 Alignment: 16-bit needs addr[0]=0; 32-bit addr[1:0]=0; 64-bit addr[2:0]=0; 8-bit always aligned.
REQ-006 Non-one-hot wdt_op SHALL be treated as misaligned (out_err=1).
REQ-007 REQ: mem_req_valid=1 with all mem_req_* stable from captured values until mem_req_ready=1; then WAIT, timeout counter cleared.
REQ-008 wmask SHALL be {1,3,15,255} for widths {8,16,32,64} shifted left by addr[2:0]; loads drive wmask=0 and wen=0.
REQ-009 WAIT: counter increments each cycle; mem_rsp_valid SHALL capture rdata shift and go DONE with out_err=0; counter reaching RSP_TIMEOUT without response SHALL go DONE with out_err=2.
REQ-010 mem_rsp_valid outside WAIT SHALL be ignored (includes same cycle as the mem_req handshake); response exactly on the RSP_TIMEOUT cycle wins over timeout.
REQ-011 out_rdata SHALL keep only the selected width's low bytes after right shift, all higher bits zero; for stores and errors out_rdata=0.
REQ-012 DONE: out_valid=1, all out_* stable until out_ready=1; then IDLE; new request accepted no earlier than the cycle after.
REQ-013 Minimum load latency: accept at cycle 0, mem_req_valid at cycle 1, response at cycle 2 earliest, out_valid at cycle 3.
REQ-014 At most one outstanding request; no pipelining or buffering beyond one op.

Reset
REQ-015 On rst=1, asynchronously: state=IDLE, counter=0, all captured registers=0, mem_req_valid=0, out_valid=0, out_err=0, out_rdata=0, req_ready=0 while rst asserted and 1 from first clock with rst deasserted.
REQ-016 Reset mid-operation SHALL abandon the op silently; any later mem_rsp_valid SHALL be ignored in IDLE.

Verification
REQ-017 lb addr=0x8000_0003, unsigned=0, rsp rdata=0x1122_3344_5566_7788 -> mem_req_addr=0x8000_0000, out_rdata=0x55, out_wdt_op=0001, out_err=0.
REQ-018 sh addr=0x...06 wdata=0xABCD -> mem_req_wmask=0xC0, mem_req_wdata=0xABCD_0000_0000_0000, out_is_store=1 after ack.
REQ-019 lw addr=0x...02 -> no mem_req_valid ever, out_valid next cycle, out_err=1.
REQ-020 RSP_TIMEOUT=4, ld, no response -> out_err=2 after 4 WAIT cycles; response on 4th cycle instead -> out_err=0.
REQ-021 mem_req_ready held 0 for 3 cycles and out_ready held 0 for 2 cycles -> mem_req_* and out_* unchanged throughout, req_ready=0.
REQ-022 rst asserted during WAIT, then stale mem_rsp_valid in IDLE -> no out_valid, next request completes normally.
